seg_display_arbiter: RTL and testbench

Shares the board's single 4-digit 7-segment display among three requesters: alert, timer and game FSM. Each requester presents a 4-nibble code word and a request line. The block grants ownership by fixed priority with a minimum-hold preemption rule, registers the owner's word and drives the multiplexed DIGIT/DISPLAY pins. It sits between the game/timer controllers and the top-level pin outputs, replacing per-controller scan logic.

---
 rtl/seg_pkg.sv | 60 ++++++
 rtl/seg7_scan.sv | 32 +++
 rtl/seg_display_arbiter.sv | 100 ++++++++++
 tb/tb_seg_display_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display path: code constants,
// digit enables, the segment pattern table and arbiter state type.
package seg_pkg;

  localparam int unsigned NUM_DISP_REQ = 3;

  localparam logic [3:0] SEG_A     = 4'd10;
  localparam logic [3:0] SEG_B     = 4'd11;
  localparam logic [3:0] SEG_DASH  = 4'd12;
  localparam logic [3:0] SEG_BLANK = 4'd15;

  localparam logic [3:0] DIG_EN0 = 4'b1110;
  localparam logic [3:0] DIG_EN1 = 4'b1101;
  localparam logic [3:0] DIG_EN2 = 4'b1011;
  localparam logic [3:0] DIG_EN3 = 4'b0111;

  typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_t;

  // Active-low segments {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg_pattern(input logic [3:0] code);
    case (code)
      4'd0:    seg_pattern = 7'b1000000;
      4'd1:    seg_pattern = 7'b1111001;
      4'd2:    seg_pattern = 7'b0100100;
      4'd3:    seg_pattern = 7'b0110000;
      4'd4:    seg_pattern = 7'b0011001;
      4'd5:    seg_pattern = 7'b0010010;
      4'd6:    seg_pattern = 7'b0000010;
      4'd7:    seg_pattern = 7'b1111000;
      4'd8:    seg_pattern = 7'b0000000;
      4'd9:    seg_pattern = 7'b0010000;
      SEG_A:   seg_pattern = 7'b0001000;
      SEG_B:   seg_pattern = 7'b0000011;
      SEG_DASH: seg_pattern = 7'b0111111;
      default: seg_pattern = 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] digit_enable(input logic [1:0] sel);
    case (sel)
      2'd0:    digit_enable = DIG_EN0;
      2'd1:    digit_enable = DIG_EN1;
      2'd2:    digit_enable = DIG_EN2;
      default: digit_enable = DIG_EN3;
    endcase
  endfunction

  function automatic logic [NUM_DISP_REQ-1:0] lowest_set(input logic [NUM_DISP_REQ-1:0] r);
    logic found;
    lowest_set = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < NUM_DISP_REQ; i++) begin
      if (r[i] && !found) begin
        lowest_set[i] = 1'b1;
        found         = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/seg7_scan.sv
// Multiplexed scan of a 4-nibble word onto the shared DIGIT/DISPLAY pins.
module seg7_scan
  import seg_pkg::*;
(
  input  logic        myclk1000hz,
  input  logic        rst_1pulse,
  input  logic [15:0] disp_word,
  output logic [3:0]  DIGIT,
  output logic [6:0]  DISPLAY
);

  logic [1:0] scan;
  logic [3:0] nibble;

  always_comb begin
    nibble = disp_word[{scan, 2'b00} +: 4];
  end

  // DIGIT and DISPLAY come from the same scan value so they never skew
  always_ff @(posedge myclk1000hz or posedge rst_1pulse) begin
    if (rst_1pulse) begin
      scan    <= '0;
      DIGIT   <= DIG_EN0;
      DISPLAY <= seg_pattern(SEG_DASH);
    end else begin
      scan    <= scan + 2'd1;
      DIGIT   <= digit_enable(scan);
      DISPLAY <= seg_pattern(nibble);
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Fixed-priority owner arbitration for the shared 4-digit display with a
// minimum-hold preemption rule; the owner's word is registered and scanned.
module seg_display_arbiter
  import seg_pkg::*;
#(
  parameter int unsigned HOLD_MS   = 500,
  parameter logic [15:0] IDLE_WORD = 16'hCCCC
) (
  input  logic                    myclk1000hz,
  input  logic                    rst_1pulse,
  input  logic [NUM_DISP_REQ-1:0] req,
  input  logic [15:0]             data0,
  input  logic [15:0]             data1,
  input  logic [15:0]             data2,
  output logic [NUM_DISP_REQ-1:0] grant,
  output logic [3:0]              DIGIT,
  output logic [6:0]              DISPLAY
);

  localparam int unsigned HW = $clog2(HOLD_MS + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_MS);

  arb_state_t state, state_n;
  logic [NUM_DISP_REQ-1:0] grant_n;
  logic [NUM_DISP_REQ-1:0] pending;
  logic [NUM_DISP_REQ-1:0] higher;
  logic [HW-1:0]           hold_cnt, hold_n;
  logic [15:0]             disp_word, owner_word;

  always_comb begin
    state_n = state;
    grant_n = grant;
    hold_n  = hold_cnt;
    pending = req & ~grant;
    // Bits below the one-hot owner are the higher-priority requesters
    higher  = req & (grant - NUM_DISP_REQ'(1));
    case (state)
      ARB_IDLE: begin
        if (|req) begin
          state_n = ARB_OWN;
          grant_n = lowest_set(req);
          hold_n  = '0;
        end
      end
      ARB_OWN: begin
        if (!(|(req & grant))) begin
          hold_n = '0;
          if (|pending) begin
            grant_n = lowest_set(pending);
          end else begin
            grant_n = '0;
            state_n = ARB_IDLE;
          end
        end else if ((|higher) && (hold_cnt == HOLD_MAX)) begin
          grant_n = lowest_set(higher);
          hold_n  = '0;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_n = hold_cnt + HW'(1);
        end
      end
      default: begin
        state_n = ARB_IDLE;
        grant_n = '0;
        hold_n  = '0;
      end
    endcase
  end

  always_comb begin
    case (grant)
      3'b001:  owner_word = data0;
      3'b010:  owner_word = data1;
      3'b100:  owner_word = data2;
      default: owner_word = IDLE_WORD;
    endcase
  end

  always_ff @(posedge myclk1000hz or posedge rst_1pulse) begin
    if (rst_1pulse) begin
      state     <= ARB_IDLE;
      grant     <= '0;
      hold_cnt  <= '0;
      disp_word <= IDLE_WORD;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      hold_cnt  <= hold_n;
      disp_word <= owner_word;
    end
  end

  seg7_scan u_scan (
    .myclk1000hz (myclk1000hz),
    .rst_1pulse  (rst_1pulse),
    .disp_word   (disp_word),
    .DIGIT       (DIGIT),
    .DISPLAY     (DISPLAY)
  );

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench: behavioural owner/pipeline model, directed scenarios
// and randomized request/data traffic compared every cycle.
module tb_seg_display_arbiter;

  localparam int HOLD = 4;
  localparam logic [15:0] IDLE_W = 16'hCCCC;

  logic        myclk1000hz = 1'b0;
  logic        rst_1pulse;
  logic [2:0]  req;
  logic [15:0] data0, data1, data2;
  logic [2:0]  grant;
  logic [3:0]  DIGIT;
  logic [6:0]  DISPLAY;

  int errors = 0;
  int checks = 0;

  int          m_owner;
  int          m_hold;
  int          m_scan;
  logic [15:0] m_word;
  logic [3:0]  m_digit;
  logic [6:0]  m_display;

  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b0111111, 7'b1111111, 7'b1111111, 7'b1111111};
  logic [3:0] dig_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  seg_display_arbiter #(.HOLD_MS(HOLD), .IDLE_WORD(IDLE_W)) dut (
    .myclk1000hz (myclk1000hz),
    .rst_1pulse  (rst_1pulse),
    .req         (req),
    .data0       (data0),
    .data1       (data1),
    .data2       (data2),
    .grant       (grant),
    .DIGIT       (DIGIT),
    .DISPLAY     (DISPLAY)
  );

  always #5 myclk1000hz = ~myclk1000hz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] word_of(input int o);
    case (o)
      0:       return data0;
      1:       return data1;
      default: return data2;
    endcase
  endfunction

  function automatic logic [2:0] m_grant();
    return (m_owner < 0) ? 3'b000 : (3'b001 << m_owner);
  endfunction

  task automatic model_reset();
    m_owner   = -1;
    m_hold    = 0;
    m_scan    = 0;
    m_word    = IDLE_W;
    m_digit   = 4'b1110;
    m_display = 7'b0111111;
  endtask

  task automatic model_step();
    int lo;
    int other;
    m_digit   = dig_seq[m_scan];
    m_display = seg_tab[(m_word >> (4 * m_scan)) & 16'hF];
    m_word    = (m_owner < 0) ? IDLE_W : word_of(m_owner);
    lo = -1;
    other = -1;
    for (int i = 2; i >= 0; i--) begin
      if (req[i]) lo = i;
      if (req[i] && i != m_owner) other = i;
    end
    if (m_owner < 0) begin
      if (lo >= 0) begin
        m_owner = lo;
        m_hold  = 0;
      end
    end else if (!req[m_owner]) begin
      m_owner = other;
      m_hold  = 0;
    end else if (lo < m_owner && m_hold == HOLD) begin
      m_owner = lo;
      m_hold  = 0;
    end else if (m_hold < HOLD) begin
      m_hold = m_hold + 1;
    end
    m_scan = (m_scan + 1) % 4;
  endtask

  task automatic compare_all();
    chk("grant", grant, m_grant());
    chk("hold_cnt", dut.hold_cnt, m_hold);
    chk("DIGIT", DIGIT, m_digit);
    chk("DISPLAY", DISPLAY, m_display);
  endtask

  task automatic step();
    @(posedge myclk1000hz);
    model_step();
    @(negedge myclk1000hz);
    compare_all();
  endtask

  task automatic reset_literals(input string tag);
    chk({tag, "_grant"}, grant, 3'b000);
    chk({tag, "_DIGIT"}, DIGIT, 4'b1110);
    chk({tag, "_DISPLAY"}, DISPLAY, 7'b0111111);
    chk({tag, "_hold"}, dut.hold_cnt, 0);
  endtask

  task automatic do_reset();
    req = 3'b000;
    rst_1pulse = 1'b1;
    #1;
    model_reset();
    reset_literals("rst");
    @(negedge myclk1000hz);
    rst_1pulse = 1'b0;
  endtask

  // Called at a falling edge: asserts reset between clock edges
  task automatic async_reset();
    #2;
    rst_1pulse = 1'b1;
    #1;
    model_reset();
    reset_literals("async_rst");
    @(negedge myclk1000hz);
    rst_1pulse = 1'b0;
  endtask

  initial begin
    req = 3'b000;
    data0 = 16'h0000;
    data1 = 16'h5678;
    data2 = 16'h1234;
    rst_1pulse = 1'b1;
    #1;
    do_reset();

    // Idle: dashes while the digit enables rotate
    for (int k = 0; k < 8; k++) begin
      step();
      chk("idle_grant", grant, 3'b000);
      chk("idle_digit", DIGIT, dig_seq[k % 4]);
      chk("idle_display", DISPLAY, 7'b0111111);
    end

    // Lowest-priority owner and its digits on the pins
    data2 = 16'h1234;
    req = 3'b100;
    step();
    chk("d2_grant", grant, 3'b100);
    for (int k = 0; k < 6; k++) begin
      step();
      if (k >= 1) begin
        if (DIGIT == 4'b1110) chk("d2_ones", DISPLAY, 7'b0011001);
        if (DIGIT == 4'b0111) chk("d2_thousands", DISPLAY, 7'b1111001);
      end
    end

    // Preemption only after the hold time has elapsed
    do_reset();
    data0 = 16'hAB12;
    req = 3'b100;
    step();
    step();
    chk("pre_hold1", dut.hold_cnt, 1);
    req = 3'b101;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("pre_wait", grant, 3'b100);
    end
    step();
    chk("pre_take", grant, 3'b001);

    // Lower priority never preempts; release hands over immediately
    for (int k = 0; k < 20; k++) begin
      step();
      chk("nopre_grant", grant, 3'b001);
    end
    req = 3'b100;
    step();
    chk("release_grant", grant, 3'b100);
    chk("release_hold", dut.hold_cnt, 0);

    // Simultaneous requests and a same-edge handover
    do_reset();
    req = 3'b110;
    step();
    chk("simul_grant", grant, 3'b010);
    req = 3'b101;
    step();
    chk("swap_grant", grant, 3'b001);

    // Asynchronous reset while owned
    do_reset();
    req = 3'b010;
    for (int k = 0; k < 3; k++) step();
    chk("own1_grant", grant, 3'b010);
    async_reset();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step();
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      if ($urandom_range(0, 15) == 0) data0 = 16'($urandom);
      if ($urandom_range(0, 15) == 0) data1 = 16'($urandom);
      if ($urandom_range(0, 15) == 0) data2 = 16'($urandom);
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
